sevenseg_scan_driver: RTL

- Parametrised, time-multiplexed N-digit seven-segment display driver. Successor to the single-digit combinational decoder.
- Adds double-buffered data loading, a refresh prescaler, digit scanning and a ghost-suppression dead cycle.
- Adds selectable common-cathode/common-anode polarity, hex/decimal glyph mode and per-digit blanking and decimal point.
- Sits between the core logic and the board's display pins.

---
 rtl/sevenseg_scan_driver.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered digit data,
// a per-slot dead cycle against ghosting, and selectable CC/CA polarity.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int COMMON_ANODE = 0,
  parameter int HEX_MODE     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    update_pending,
  output logic                    frame_done
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic INV = (COMMON_ANODE != 0);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] DASH = 7'b0000001;

  logic [PRE_W-1:0] prescaler;
  logic [IDX_W-1:0] idx;
  logic tick;
  logic boundary;
  logic boundary_q;

  logic [4*NUM_DIGITS-1:0] active_data;
  logic [NUM_DIGITS-1:0]   active_blank;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic [3:0]            cur_code;
  logic                  cur_blank;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] sel;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] en_next;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    g = DASH;
    case (code)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'ha: g = 7'b1110111;
      4'hb: g = 7'b0011111;
      4'hc: g = 7'b1001110;
      4'hd: g = 7'b0111101;
      4'he: g = 7'b1001111;
      4'hf: g = 7'b1000111;
    endcase
    if (HEX_MODE == 0 && code > 4'd9) g = DASH;
    return g;
  endfunction

  assign tick     = (prescaler == PRE_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // A load landing exactly on the frame boundary bypasses the shadow so it is not lost a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_data    <= '0;
      active_blank   <= '0;
      active_dp      <= '0;
      shadow_data    <= '0;
      shadow_blank   <= '0;
      shadow_dp      <= '0;
      update_pending <= 1'b0;
    end else if (load && boundary) begin
      active_data    <= data_in;
      active_blank   <= blank_in;
      active_dp      <= dp_in;
      update_pending <= 1'b0;
    end else begin
      if (boundary && update_pending) begin
        active_data    <= shadow_data;
        active_blank   <= shadow_blank;
        active_dp      <= shadow_dp;
        update_pending <= 1'b0;
      end
      if (load) begin
        shadow_data    <= data_in;
        shadow_blank   <= blank_in;
        shadow_dp      <= dp_in;
        update_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    sel       = '0;
    seg_next  = '0;
    dp_next   = 1'b0;
    en_next   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_code  = active_data[4*k +: 4];
        cur_blank = active_blank[k];
        cur_dp    = active_dp[k];
        sel[k]    = 1'b1;
      end
    end
    // First cycle of every slot stays dark so the previous digit's segments cannot ghost.
    if (prescaler != '0) begin
      en_next = sel;
      if (!cur_blank) begin
        seg_next = glyph(cur_code);
        dp_next  = cur_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= {7{INV}};
      dp_out     <= INV;
      digit_en   <= {NUM_DIGITS{INV}};
      boundary_q <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_next ^ {7{INV}};
      dp_out     <= dp_next ^ INV;
      digit_en   <= en_next ^ {NUM_DIGITS{INV}};
      boundary_q <= boundary;
      frame_done <= boundary_q;
    end
  end

endmodule
